lock_equiv_sweeper: RTL and testbench

LOCK_EQUIV_SWEEPER -- requirements
Module: lock_equiv_sweeper

---
 rtl/lock_equiv_sweeper_pkg.sv | 15 +
 rtl/lock_equiv_sweeper_sweep_counter.sv | 39 +++
 rtl/lock_equiv_sweeper.sv | 142 ++++++++++++++
 tb/tb_lock_equiv_sweeper.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/lock_equiv_sweeper_pkg.sv
// Shared types and default widths for the key-equivalence sweeper.
// The state encoding is shared by the top FSM and any monitor that decodes it.
package lock_equiv_sweeper_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_IN_W  = 5;
  localparam int DEF_OUT_W = 2;
  localparam int DEF_KEY_W = 1;

endpackage

// File: rtl/lock_equiv_sweeper_sweep_counter.sv
// Pattern counter for the sweep: clears on request, advances on enable and
// saturates at all-ones so the last pattern is held rather than wrapped.
module sweep_counter
  import lock_equiv_sweeper_pkg::*;
#(
  parameter int W = DEF_IN_W
) (
  input  logic         C,
  input  logic         R,
  input  logic         clr,
  input  logic         adv,
  output logic [W-1:0] count,
  output logic         last
);

  logic [W-1:0] count_reg;
  logic [W-1:0] count_next;

  assign last  = &count_reg;
  assign count = count_reg;

  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (adv && !last) begin
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge C) begin
    if (R) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/lock_equiv_sweeper.sv
// Exhaustively drives every input pattern to an original and a locked circuit
// under a captured key, and accumulates where their outputs disagree.
module lock_equiv_sweeper
  import lock_equiv_sweeper_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int KEY_W = DEF_KEY_W
) (
  input  logic             C,
  input  logic             R,
  input  logic             start,
  input  logic             abort,
  input  logic [KEY_W-1:0] key_in,
  input  logic [OUT_W-1:0] org_y,
  input  logic [OUT_W-1:0] enc_y,
  output logic [IN_W-1:0]  pat,
  output logic [KEY_W-1:0] key_o,
  output logic             busy,
  output logic             done,
  output logic [IN_W:0]    mism_cnt,
  output logic [IN_W-1:0]  first_fail,
  output logic             fail_valid,
  output logic [OUT_W-1:0] out_diff,
  output logic             eq_all
);

  state_t state_reg, state_next;

  logic clr;
  logic adv;
  logic acc;
  logic last;

  logic [OUT_W-1:0] diff;
  logic             miss;

  logic [KEY_W-1:0] key_reg, key_next;
  logic [IN_W:0]    mism_reg, mism_next;
  logic [IN_W-1:0]  first_reg, first_next;
  logic             fv_reg, fv_next;
  logic [OUT_W-1:0] od_reg, od_next;
  logic             eq_reg, eq_next;

  sweep_counter #(.W(IN_W)) u_cnt (
    .C     (C),
    .R     (R),
    .clr   (clr),
    .adv   (adv),
    .count (pat),
    .last  (last)
  );

  always_ff @(posedge C) begin
    if (R) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // abort wins over the last-pattern exit so an aborted sweep never reports done
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = SWEEP;
      SWEEP: begin
        if (abort)     state_next = IDLE;
        else if (last) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg == SWEEP);
    done = (state_reg == DONE);
    clr  = (state_reg == IDLE) && start;
    acc  = (state_reg == SWEEP) && !abort;
    adv  = acc && !last;
  end

  assign diff = org_y ^ enc_y;
  assign miss = |diff;

  always_comb begin
    key_next   = key_reg;
    mism_next  = mism_reg;
    first_next = first_reg;
    fv_next    = fv_reg;
    od_next    = od_reg;
    eq_next    = eq_reg;
    if (clr) begin
      key_next   = key_in;
      mism_next  = '0;
      first_next = '0;
      fv_next    = 1'b0;
      od_next    = '0;
      eq_next    = 1'b0;
    end else if (acc) begin
      if (miss) begin
        mism_next = mism_reg + 1'b1;
        od_next   = od_reg | diff;
        if (!fv_reg) begin
          first_next = pat;
          fv_next    = 1'b1;
        end
      end
      // verdict lands together with the done pulse, including the final compare
      if (last) begin
        eq_next = (mism_next == '0);
      end
    end
  end

  always_ff @(posedge C) begin
    if (R) begin
      key_reg   <= '0;
      mism_reg  <= '0;
      first_reg <= '0;
      fv_reg    <= 1'b0;
      od_reg    <= '0;
      eq_reg    <= 1'b0;
    end else begin
      key_reg   <= key_next;
      mism_reg  <= mism_next;
      first_reg <= first_next;
      fv_reg    <= fv_next;
      od_reg    <= od_next;
      eq_reg    <= eq_next;
    end
  end

  assign key_o      = key_reg;
  assign mism_cnt   = mism_reg;
  assign first_fail = first_reg;
  assign fail_valid = fv_reg;
  assign out_diff   = od_reg;
  assign eq_all     = eq_reg;

endmodule

// File: tb/tb_lock_equiv_sweeper.sv
// Directed bench for lock_equiv_sweeper: a toy original circuit plus a locked
// copy whose corruption pattern is selected per scenario.
module tb_lock_equiv_sweeper;

  localparam int IN_W  = 5;
  localparam int OUT_W = 2;
  localparam int KEY_W = 1;

  logic             C = 1'b0;
  logic             R = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [KEY_W-1:0] key_in = '0;
  logic [OUT_W-1:0] org_y;
  logic [OUT_W-1:0] enc_y;
  logic [IN_W-1:0]  pat;
  logic [KEY_W-1:0] key_o;
  logic             busy;
  logic             done;
  logic [IN_W:0]    mism_cnt;
  logic [IN_W-1:0]  first_fail;
  logic             fail_valid;
  logic [OUT_W-1:0] out_diff;
  logic             eq_all;

  int checks = 0;
  int errors = 0;
  int mode   = 0;

  lock_equiv_sweeper #(.IN_W(IN_W), .OUT_W(OUT_W), .KEY_W(KEY_W)) dut (
    .C          (C),
    .R          (R),
    .start      (start),
    .abort      (abort),
    .key_in     (key_in),
    .org_y      (org_y),
    .enc_y      (enc_y),
    .pat        (pat),
    .key_o      (key_o),
    .busy       (busy),
    .done       (done),
    .mism_cnt   (mism_cnt),
    .first_fail (first_fail),
    .fail_valid (fail_valid),
    .out_diff   (out_diff),
    .eq_all     (eq_all)
  );

  always #5 C = ~C;

  // mode 0: equal, 1: bit0 flip at 5/20, 2: full invert, 3: bit1 flip at 3/12
  always_comb begin
    org_y = pat[1:0] ^ pat[4:3];
    enc_y = org_y;
    case (mode)
      1: if (pat == 5'd5 || pat == 5'd20) enc_y = org_y ^ 2'b01;
      2: enc_y = ~org_y;
      3: if (pat == 5'd3 || pat == 5'd12) enc_y = org_y ^ 2'b10;
      default: enc_y = org_y;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulses start at a falling edge and returns the 1-based cycle (the cycle
  // opened by the start edge is 1) in which done is seen; 0 if never seen.
  // restart_at >= 0 re-pulses start with the other key while pat matches.
  task automatic run_sweep(input logic [KEY_W-1:0] key, input int restart_at, output int cyc);
    cyc = 0;
    @(negedge C);
    key_in = key;
    start  = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge C);
      start  = 1'b0;
      key_in = key;
      if (done) begin
        cyc = i;
        break;
      end
      if (busy && restart_at >= 0 && int'(pat) == restart_at) begin
        start  = 1'b1;
        key_in = ~key;
      end
    end
    $display("sweep mode=%0d key=%0d done_cycle=%0d mism=%0d first=%0d fv=%0d diff=%b",
             mode, key, cyc, mism_cnt, first_fail, fail_valid, out_diff);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pat"},   32'(pat), 0);
    check({tag, "_key"},   32'(key_o), 0);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_done"},  32'(done), 0);
    check({tag, "_mism"},  32'(mism_cnt), 0);
    check({tag, "_first"}, 32'(first_fail), 0);
    check({tag, "_fv"},    32'(fail_valid), 0);
    check({tag, "_diff"},  32'(out_diff), 0);
    check({tag, "_eq"},    32'(eq_all), 0);
  endtask

  initial begin
    int cyc;
    int hit;
    int seen;

    repeat (3) @(negedge C);
    R = 1'b0;
    @(negedge C);
    check_reset_state("reset");

    // equivalent circuits
    mode = 0;
    run_sweep(1'b1, -1, cyc);
    check("eq_done_cycle", 32'(cyc), 33);
    check("eq_mism", 32'(mism_cnt), 0);
    check("eq_fv", 32'(fail_valid), 0);
    @(negedge C);
    check("eq_eq_all", 32'(eq_all), 1);
    check("eq_done_low", 32'(done), 0);
    check("eq_busy_low", 32'(busy), 0);
    check("eq_key", 32'(key_o), 1);

    // two isolated single-bit mismatches
    mode = 1;
    run_sweep(1'b0, -1, cyc);
    check("two_done_cycle", 32'(cyc), 33);
    check("two_mism", 32'(mism_cnt), 2);
    check("two_first", 32'(first_fail), 5);
    check("two_fv", 32'(fail_valid), 1);
    check("two_diff", 32'(out_diff), 2'b01);
    @(negedge C);
    check("two_eq_all", 32'(eq_all), 0);
    check("two_key", 32'(key_o), 0);

    // every pattern mismatches: counter reaches 2^IN_W without wrapping
    mode = 2;
    run_sweep(1'b1, -1, cyc);
    check("all_done_cycle", 32'(cyc), 33);
    check("all_mism", 32'(mism_cnt), 32);
    check("all_first", 32'(first_fail), 0);
    check("all_diff", 32'(out_diff), 2'b11);
    check("all_pat_hold", 32'(pat), 31);
    @(negedge C);
    check("all_eq_all", 32'(eq_all), 0);

    // start during SWEEP is ignored, key unchanged
    mode = 0;
    run_sweep(1'b0, 10, cyc);
    check("restart_done_cycle", 32'(cyc), 33);
    check("restart_key", 32'(key_o), 0);
    @(negedge C);
    check("restart_eq_all", 32'(eq_all), 1);

    // synchronous reset mid-sweep after a mismatch has been recorded
    mode = 1;
    @(negedge C);
    key_in = 1'b1;
    start  = 1'b1;
    hit = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge C);
      start = 1'b0;
      if (busy && pat == 5'd17) begin
        R = 1'b1;
        hit = 1;
        break;
      end
    end
    check("rst_reached_17", 32'(hit), 1);
    @(negedge C);
    R = 1'b0;
    check_reset_state("rst_mid");
    $display("reset at pat=17 applied");
    run_sweep(1'b1, -1, cyc);
    check("rst_after_cycle", 32'(cyc), 33);
    check("rst_after_mism", 32'(mism_cnt), 2);
    check("rst_after_key", 32'(key_o), 1);

    // abort at pat 12: the compare at 12 is not accounted
    mode = 3;
    @(negedge C);
    key_in = 1'b0;
    start  = 1'b1;
    hit = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge C);
      start = 1'b0;
      if (busy && pat == 5'd12) begin
        abort = 1'b1;
        hit = 1;
        break;
      end
    end
    check("abort_reached_12", 32'(hit), 1);
    @(negedge C);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen = 1;
      @(negedge C);
    end
    check("abort_no_done", 32'(seen), 0);
    check("abort_mism", 32'(mism_cnt), 1);
    check("abort_first", 32'(first_fail), 3);
    check("abort_fv", 32'(fail_valid), 1);
    check("abort_diff", 32'(out_diff), 2'b10);
    check("abort_eq_all", 32'(eq_all), 0);
    $display("abort at pat=12 mism=%0d first=%0d", mism_cnt, first_fail);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
